// File: rtl/dip_debounce.sv
// -----------------------------------------------------------------------------
// dip_debounce
//
// Synchronises and debounces the raw DIP switch levels before they become the
// stepper-counter step value. Each bit is qualified against a tick derived from
// the rising edge of one shared timebase tap, so no private prescaler is needed.
//
// Parameters
//   NTAPS        width of the timebase tap bus
//   TAP_SEL      tap whose rising edge is the sample tick (< NTAPS)
//   STABLE_TICKS consecutive mismatching ticks needed to accept a new value (>= 1)
//   WIDTH        number of switch bits
//
// Ports
//   clk      in   system clock (clk_sys)
//   rst_n    in   asynchronous active-low reset
//   taps     in   timebase taps, synchronous to clk
//   raw      in   asynchronous switch levels, bit 0 = S1
//   val      out  debounced switch word, registered
//   changed  out  one-cycle pulse in the cycle val takes a new value
//   stable   out  high when every synchronised bit equals val and no count is pending
// -----------------------------------------------------------------------------
module dip_debounce #(
    parameter int NTAPS        = 7,
    parameter int TAP_SEL      = 3,
    parameter int STABLE_TICKS = 4,
    parameter int WIDTH        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NTAPS-1:0] taps,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] val,
    output logic             changed,
    output logic             stable
);

    localparam int            CW       = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    // Registered state
    logic [WIDTH-1:0]         s1_q;
    logic [WIDTH-1:0]         s2_q;
    logic                     tap_q;
    logic [WIDTH-1:0]         val_q;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic                     changed_q;
    logic                     stable_q;

    // Next-state values
    logic [WIDTH-1:0]         val_d;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic                     changed_d;
    logic                     stable_d;
    logic                     tick;

    // Only one tap feeds the filter; fold the rest so they are not left dangling.
    logic unused_taps;
    assign unused_taps = ^taps;

    // One-cycle tick on the rising edge of the selected tap. tap_q resets to 0,
    // so a tap already high right after reset release counts as a tick.
    assign tick = taps[TAP_SEL] & ~tap_q;

    // Per-bit filter. Returning to the accepted level always clears the count,
    // with or without a tick, which cancels any pending change.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic mismatch;
        logic at_last;

        assign mismatch = s2_q[gi] ^ val_q[gi];
        assign at_last  = (cnt_q[gi] == CNT_LAST);

        assign val_d[gi] = (mismatch && tick && at_last) ? s2_q[gi] : val_q[gi];
        assign cnt_d[gi] = !mismatch ? '0 :
                           !tick     ? cnt_q[gi] :
                           at_last   ? '0 :
                                       cnt_q[gi] + CW'(1);
    end

    assign changed_d = |(val_d ^ val_q);

    // Uses current s2 against next val so stable drops one edge after s2 moves
    // (three edges after raw) and recovers on the accepting edge itself.
    assign stable_d  = (s2_q == val_d) && (cnt_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            tap_q     <= 1'b0;
            val_q     <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b1;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            tap_q     <= taps[TAP_SEL];
            val_q     <= val_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            stable_q  <= stable_d;
        end
    end

    assign val     = val_q;
    assign changed = changed_q;
    assign stable  = stable_q;

endmodule
